// File: rtl/wind_mode_pkg.sv
// Shared definitions for the wind-direction mode controller: mode encodings,
// debounce FSM states, default timing constants and the switch-value filter
// used when the optional invalid-value hold (WIND_MODE_INVALID_HOLD_EN) is built in.
package wind_mode_pkg;

  // Accepted mode values presented to the hazard-light stage.
  localparam logic [1:0] MODE_CALM  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  // Debounce FSM: STABLE tracks the committed mode, SETTLE is qualifying a candidate.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  // Default timing: clocks a new value must persist, and clocks per pattern step.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_TICK_DIV        = 8;

  // Value the FSM actually compares against. With the hold enabled, the
  // "both switches closed" reading is not a real direction and is folded
  // onto the current mode so it can neither start nor continue a change.
  function automatic logic [1:0] effective_mode(
    input logic [1:0] sw_s,
    input logic [1:0] cur_mode,
    input logic       hold_en
  );
    logic [1:0] result;
    result = sw_s;
    if (hold_en && (sw_s == MODE_OFF)) begin
      result = cur_mode;
    end
    return result;
  endfunction

endpackage

// File: rtl/wind_mode_ctrl_if.sv
// Bundle of the switch input and hazard-light-stage outputs of wind_mode_ctrl.
// master: the switch/consumer side; slave: the controller itself.
interface wind_mode_ctrl_if;

  logic [1:0] sw;            // raw, bouncy, asynchronous switch pair
  logic [1:0] x;             // accepted mode
  logic       tick;          // one-cycle pattern step enable
  logic       mode_changed;  // one-cycle pulse in the cycle after x changes

  modport master (
    output sw,
    input  x,
    input  tick,
    input  mode_changed
  );

  modport slave (
    input  sw,
    output x,
    output tick,
    output mode_changed
  );

endinterface

// File: rtl/wind_mode_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous inputs. Both stages clear to zero
// on the asynchronous active-high reset; output latency is two clocks.
module sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_q, stage1_d;
  logic [WIDTH-1:0] stage2_q, stage2_d;

  // Next values: shift the raw input one stage per clock.
  always_comb begin
    stage1_d = d;
    stage2_d = stage1_q;
  end

  // Synchronizer stages; the first one may go metastable, the second filters it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/wind_mode_ctrl.sv
// Wind-direction mode controller: synchronizes the bouncy switch pair,
// debounces it into an accepted mode x, and divides the clock into the
// pattern-step tick for the hazard-light stage. A commit restarts the tick
// phase so the new pattern always begins with a full step.
// Optional build macro: WIND_MODE_INVALID_HOLD_EN -- when defined, a switch
// reading of 11 is ignored (treated as the current mode) instead of debounced.
module wind_mode_ctrl
  import wind_mode_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // 1..255
  parameter int TICK_DIV        = DEFAULT_TICK_DIV          // 2..65535
) (
  input  logic            clk,
  input  logic            reset,
  wind_mode_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);

  // The count holds how many consecutive samples have matched the candidate.
  // The sample that would bring it to DEBOUNCE_CYCLES commits instead, so the
  // stored count stays below DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

`ifdef WIND_MODE_INVALID_HOLD_EN
  localparam logic HOLD_EN = 1'b1;
`else
  localparam logic HOLD_EN = 1'b0;
`endif

  logic [1:0]    sw_s;
  logic [1:0]    sw_eff;

  state_e        state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    x_q, x_d;
  logic          mode_changed_q, mode_changed_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          commit;
  logic          tick_w;

  sync2 #(
    .WIDTH(2)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.sw),
    .q    (sw_s)
  );

  assign sw_eff = effective_mode(sw_s, x_q, HOLD_EN);

  // Debounce FSM next state: qualify a new value over consecutive samples,
  // abandon it on a bounce back, restart on a different new value.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    x_d     = x_q;
    commit  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sw_eff == x_q) begin
          count_d = '0;
        end else if (DEBOUNCE_CYCLES == 1) begin
          // A single matching sample is already enough.
          commit  = 1'b1;
          x_d     = sw_eff;
          cand_d  = sw_eff;
          count_d = '0;
        end else begin
          state_d = ST_SETTLE;
          cand_d  = sw_eff;
          count_d = CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (sw_eff == x_q) begin
          state_d = ST_STABLE;
          count_d = '0;
        end else if (sw_eff == cand_q) begin
          if (count_q >= CNT_LAST) begin
            commit  = 1'b1;
            x_d     = cand_q;
            state_d = ST_STABLE;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          cand_d  = sw_eff;
          count_d = CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        count_d = '0;
      end
    endcase
  end

  // Tick divider and change pulse: a commit clears the divider and masks a
  // coincident wrap so the new mode starts on a full step.
  always_comb begin
    mode_changed_d = commit;
    if (commit || (tick_cnt_q == TICK_LAST)) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end
    tick_w = (tick_cnt_q == TICK_LAST) && !commit;
  end

  // State registers; reset returns everything to calm / phase zero at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_STABLE;
      cand_q         <= MODE_CALM;
      count_q        <= '0;
      x_q            <= MODE_CALM;
      mode_changed_q <= 1'b0;
      tick_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      count_q        <= count_d;
      x_q            <= x_d;
      mode_changed_q <= mode_changed_d;
      tick_cnt_q     <= tick_cnt_d;
    end
  end

  assign bus.x            = x_q;
  assign bus.tick         = tick_w;
  assign bus.mode_changed = mode_changed_q;

endmodule

// File: tb/tb_wind_mode_ctrl.sv
// Scoreboard bench for wind_mode_ctrl (DEBOUNCE_CYCLES=4, TICK_DIV=8).
// The reference model works from a sliding window of synchronized samples:
// x takes value v once the last DEBOUNCE_CYCLES samples all equal v != x.
// Ticks fall on every TICK_DIV-th cycle since the last reset or commit,
// except in a cycle whose closing edge commits.
module tb_wind_mode_ctrl;
  import wind_mode_pkg::*;

  localparam int D  = 4;
  localparam int TD = 8;

`ifdef WIND_MODE_INVALID_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  wind_mode_ctrl_if bus ();

  wind_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV       (TD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // Expected {x, tick, mode_changed} for each cycle, pushed at the rising edge.
  logic [3:0] exp_q[$];

  // Reference model state.
  logic [1:0] sw_drv = 2'b00;
  logic [1:0] m_s1   = 2'b00;
  logic [1:0] m_s2   = 2'b00;
  logic [1:0] m_x    = 2'b00;
  logic [1:0] m_hist[$];
  int         m_cyc   = 0;
  int         m_clear = 0;
  bit         m_rst   = 1'b1;

  function automatic logic [1:0] eff(input logic [1:0] s, input logic [1:0] cur);
    return (HOLD_EN && s == 2'b11) ? cur : s;
  endfunction

  // Would appending sample s make the window D identical values differing from x?
  function automatic bit window_commits(input logic [1:0] s);
    logic [1:0] w[$];
    w = m_hist;
    w.push_back(s);
    if (w.size() > D) void'(w.pop_front());
    if (w.size() != D) return 1'b0;
    foreach (w[i]) if (w[i] != w[0]) return 1'b0;
    return w[0] != m_x;
  endfunction

  // Reference model: advances at each rising edge and queues the expectation
  // for the cycle that follows.
  initial begin
    forever begin
      logic [1:0] s;
      bit         c;
      bit         next_c;
      bit         tk;
      @(posedge clk);
      m_cyc++;
      c = 1'b0;
      if (m_rst) begin
        m_s1 = 2'b00;
        m_s2 = 2'b00;
        m_x  = 2'b00;
        m_hist.delete();
        m_clear = m_cyc;
      end else begin
        s = eff(m_s2, m_x);
        c = window_commits(s);
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        if (c) begin
          m_x = s;
          m_hist.delete();
          m_clear = m_cyc;
        end
        m_s2 = m_s1;
        m_s1 = sw_drv;
      end
      next_c = !m_rst && window_commits(eff(m_s2, m_x));
      tk = (((m_cyc - m_clear) % TD) == TD - 1) && !next_c;
      exp_q.push_back({m_x, tk, c});
    end
  end

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial begin
    forever begin
      logic [3:0] got;
      logic [3:0] want;
      @(posedge clk);
      #1;
      if (done) break;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at cycle %0d", m_cyc);
      end else begin
        want = exp_q.pop_front();
        got  = {bus.x, bus.tick, bus.mode_changed};
        if (got !== want) begin
          errors++;
          $display("FAIL outputs cycle %0d x/tick/mc got %b_%b_%b want %b_%b_%b",
                   m_cyc, got[3:2], got[1], got[0], want[3:2], want[1], want[0]);
        end else if (got[0]) begin
          $display("commit cycle %0d x=%b", m_cyc, got[3:2]);
        end
      end
    end
  end

  task automatic hold(input logic [1:0] v, input int n);
    sw_drv = v;
    bus.sw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input int n);
    logic [3:0] got;
    reset = 1'b1;
    m_rst = 1'b1;
    #1;
    got = {bus.x, bus.tick, bus.mode_changed};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset x/tick/mc got %b want 0000", got);
    end
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
    m_rst = 1'b0;
  endtask

  initial begin
    bus.sw = 2'b00;
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    m_rst = 1'b0;

    hold(2'b00, 20);                    // idle: ticks on cycles 8 and 16
    hold(2'b01, 12);                    // clean change to right
    hold(2'b00, 12);                    // back to calm
    hold(2'b10, 2);  hold(2'b00, 10);   // short glitch rejected
    hold(2'b01, 2);  hold(2'b10, 12);   // candidate replaced, left commits
    do_reset(2);
    hold(2'b00, 2);  hold(2'b01, 14);   // commit lands on the tick-wrap cycle
    hold(2'b10, 3);  do_reset(2);       // reset while settling
    hold(2'b10, 10);                    // full latency again after release
    hold(2'b11, 12);                    // 11 held: build-dependent outcome
    hold(2'b00, 10);

    repeat (150) begin
      logic [1:0] v;
      int         n;
      v = 2'($urandom_range(0, 3));
      n = $urandom_range(1, D + 4);
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      hold(v, n);
    end

    @(posedge clk);
    #3;
    done = 1'b1;
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wind_mode_ctrl.md
WIND_MODE_CTRL -- requirements
Module: wind_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized clocks a new switch value must hold before it is accepted; legal range 1..255.
REQ-002 Parameter TICK_DIV, default 8: clk cycles per pattern-step tick; legal range 2..65535.
REQ-003 Port clk, input, 1: single system clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port sw, input, 2: raw, asynchronous, bouncy wind-direction switches.
REQ-006 Port x, output, 2: accepted mode to the hazard-light stage (00 calm, 01 right, 10 left, 11 off).
REQ-007 Port tick, output, 1: one-cycle step-enable pulse for the hazard-light stage.
REQ-008 Port mode_changed, output, 1: one-cycle pulse marking the cycle after x changes.

Function
REQ-009 sw SHALL pass through a two-flop synchronizer; its output is sw_s, with 2-cycle latency.
REQ-010 The FSM SHALL have states STABLE and SETTLE, plus internal registers candidate[1:0] and a debounce count.
REQ-011 In STABLE with sw_s == x, the FSM SHALL stay in STABLE with count 0.
REQ-012 In STABLE with sw_s != x, the FSM SHALL enter SETTLE, set candidate = sw_s and set count = 1.
REQ-013 In SETTLE with sw_s == candidate and count < DEBOUNCE_CYCLES, count SHALL increment.
REQ-014 In SETTLE with sw_s == candidate and count == DEBOUNCE_CYCLES, the FSM SHALL commit: x <= candidate, mode_changed = 1 the next cycle, return to STABLE.
REQ-015 In SETTLE with sw_s == x (bounce back), the FSM SHALL return to STABLE with no commit and count 0.
REQ-016 In SETTLE with sw_s != candidate and sw_s != x, the FSM SHALL set candidate = sw_s and restart count at 1.
REQ-017 End-to-end, x SHALL update at the rising edge 2+DEBOUNCE_CYCLES after sw becomes stable (edge 1 is the first sampling edge).
REQ-018 The tick counter SHALL run 0..TICK_DIV-1 and wrap to 0; tick = 1 exactly while the count equals TICK_DIV-1.
REQ-019 On a commit edge, the tick counter SHALL clear to 0, so the first tick after a mode change arrives TICK_DIV cycles later.
REQ-020 If a commit and a tick wrap coincide, the commit SHALL win: the counter clears and no extra tick is emitted.
REQ-021 The count register width SHALL be $clog2(DEBOUNCE_CYCLES+1), and the count SHALL never exceed DEBOUNCE_CYCLES.

Reset
REQ-022 Asserting reset SHALL immediately set x = 00, tick = 0, mode_changed = 0, sync flops = 00, candidate = 00, count = 0, tick counter = 0, state = STABLE.
REQ-023 Reset asserted mid-SETTLE SHALL discard the candidate; after release, a held sw SHALL require a full 2+DEBOUNCE_CYCLES latency.
REQ-024 The first tick after reset release SHALL occur at cycle TICK_DIV.

Configuration
REQ-025 With WIND_MODE_INVALID_HOLD_EN defined, sw_s == 11 SHALL be treated as equal to x: no SETTLE entry, and any SETTLE in progress returns to STABLE.
REQ-026 With WIND_MODE_INVALID_HOLD_EN undefined, 11 SHALL debounce and commit like any other value.

Structure
REQ-027 Package wind_mode_pkg SHALL hold the mode encodings (MODE_CALM, MODE_RIGHT, MODE_LEFT, MODE_OFF), the FSM state enum, and the default DEBOUNCE_CYCLES/TICK_DIV constants.
REQ-028 The synchronizer SHALL be the sub-module sync2 (parameterized width, async active-high reset); the debounce FSM and tick divider SHALL stay in wind_mode_ctrl.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-029 Reset, then sw=00 held 20 cycles -> x=00, mode_changed never 1, tick high at cycles 8 and 16.
REQ-030 sw 00->01 held -> x=01 at the 6th edge, mode_changed high one cycle, next tick 8 cycles after commit.
REQ-031 sw 00->10 for 2 cycles then back to 00 -> x stays 00, no mode_changed.
REQ-032 sw 00->01 for 2 cycles then 10 held -> candidate restarts and x=10 commits 4 edges after sw_s shows 10; x never equals 01.
REQ-033 Commit forced on the tick-wrap cycle (count 7) -> no tick that cycle, next tick 8 cycles later; reset asserted mid-SETTLE -> outputs cleared asynchronously, no commit after release.
REQ-034 sw=11 held -> with WIND_MODE_INVALID_HOLD_EN, x unchanged; without it, x=11 after 6 edges.
